// File: rtl/stopwatch_disp_pkg.sv
// Shared constants for the stopwatch 7-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package stopwatch_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/stopwatch_seg_display_enc.sv
// bcd_to_7seg: 4-bit BCD to active-low 7-segment pattern.
// Nibbles A-F show a dash so corrupt time is visible.
module bcd_to_7seg
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // table lookup with dash fallback for non-BCD input
  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/stopwatch_seg_display.sv
// stopwatch_seg_display: 6-digit multiplexed common-anode driver.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros on digits 5..3.
module stopwatch_seg_display
  import stopwatch_disp_pkg::*;
#(
  parameter int          REFRESH_DIV = 100000,
  parameter logic [5:0]  DP_MASK     = 6'b010100
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] disp_time,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic [23:0]   snap;
  logic [23:0]   snap_nx;
  logic          live;
  logic          tick;
  logic          load;
  logic          blank;
  logic [3:0]    digit;
  logic [6:0]    enc;

  assign tick = (div == DIV_MAX);
  assign load = (div == '0) && (idx == 3'd0);

  // The snapshot edge also drives digit 0, so encode the value
  // being captured rather than the stale one.
  assign snap_nx = load ? disp_time : snap;
  assign digit   = snap_nx[{idx, 2'b00} +: 4];

  bcd_to_7seg u_enc (
    .bcd (digit),
    .seg (enc)
  );

  // leading-zero detection for the upper three digits
  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (1'b1)
      idx == 3'd5: blank = (snap_nx[23:20] == 4'h0);
      idx == 3'd4: blank = (snap_nx[23:16] == 8'h0);
      idx == 3'd3: blank = (snap_nx[23:12] == 12'h0);
      default:     blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  // refresh divider, digit index, frame snapshot and frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div        <= '0;
      idx        <= 3'd0;
      snap       <= 24'h0;
      live       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      live       <= 1'b1;
      div        <= tick ? '0 : div + 1'b1;
      frame_done <= tick && (idx == LAST);
      if (tick) idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
      if (load) snap <= disp_time;
    end
  end

  // registered pin drive; held blank until the first snapshot lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 6'b111111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (live) begin
      an  <= ~(6'b000001 << idx);
      seg <= blank ? SEG_BLANK : enc;
      dp  <= blank ? 1'b1 : ~DP_MASK[idx];
    end
  end

endmodule

// File: doc/stopwatch_seg_display.md
Name: stopwatch_seg_display

Overview:
- Consumes the stopwatch's 24-bit disp_time (six packed BCD digits) and drives a 6-digit, time-multiplexed, common-anode 7-segment display.
- Sits between the stopwatch core and the board pins.
- Scans one digit per refresh tick.
- Latches a fresh snapshot of disp_time once per full scan frame so a frame never mixes two time values.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is held (>=2).
- DP_MASK, 6'b010100, bit i = 1 lights the decimal point on digit i (separators).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- disp_time  input  24  six BCD digits; digit i = disp_time[4*i+3:4*i], digit 0 least significant (rightmost)
- an  output  6  digit enables, active-low, one-hot-cold; an[i] selects digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_done  output  1  one-cycle pulse when the digit 5 slot ends

Behaviour:
- Reset (reset=0, asynchronous): div=0, idx=0, snap=24'h0, an=6'b111111, seg=7'h7F, dp=1, frame_done=0.
- Divider div counts 0..REFRESH_DIV-1 and then wraps. tick = (div==REFRESH_DIV-1).
- Digit index idx counts 0..5. It advances on tick and wraps 5->0.
- frame_done=1 in the cycle after the tick where idx goes 5->0.
- Snapshot: snap<=disp_time on every edge where div==0 && idx==0. This includes the first edge after reset is released. snap is held for the rest of the frame.
- Output stage is registered, 1-cycle latency from (idx, snap) to (an, seg, dp):
  - an = ~(6'b1 << idx)
  - seg = enc(snap digit idx)
  - dp = ~DP_MASK[idx]
- The first valid digit-0 drive appears on the 2nd rising edge after reset is released.
- Each digit is held exactly REFRESH_DIV cycles. A full frame is 6*REFRESH_DIV cycles.
- enc (active-low gfedcba):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - Non-BCD nibble (A-F) = 0x3F (dash, g segment only)
- disp_time changing on the snapshot edge: the value sampled at that edge is used.
- disp_time changing mid-frame: ignored until the next frame.
- Reset asserted mid-scan: outputs blank immediately (asynchronous). Scanning restarts at digit 0 with a new snapshot.
- an never has more than one bit low, and is never low during reset.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digits 5, 4 and 3 are blanked (seg=0x7F, dp=1, an still strobes) when that digit and all more-significant digits in snap are 0. Digits 2..0 are never blanked.
- Undefined: all six digits always display, including leading zeros.

Decomposition:
- Package stopwatch_disp_pkg holds:
  - SEG_BLANK (7'h7F) and SEG_DASH (7'h3F)
  - NUM_DIGITS=6
  - the 10-entry BCD segment table
- One natural sub-module: bcd_to_7seg, a combinational 4-bit -> 7-bit active-low encoder including the dash case. The top instantiates one copy ahead of the output register.

Test Plan:
- Reset hold: reset=0 for 10 cycles -> an=6'b111111, seg=7'h7F, dp=1, frame_done=0 throughout.
- Scan order (REFRESH_DIV=4, disp_time=24'h123456):
  - Expected per-digit drives: an=111110/seg=0x02, then 111101/0x12, 111011/0x19 with dp=0, 110111/0x30, 101111/0x24 with dp=0, 011111/0x79.
  - Each drive lasts 4 cycles. frame_done pulses every 24 cycles.
- Snapshot integrity: disp_time=24'h000000, change to 24'h999999 while idx=2 -> remaining digits of the frame show 0x40. The next frame shows 0x10 on every digit.
- Invalid BCD: disp_time=24'h00000A -> digit 0 seg=0x3F, all other digits 0x40.
- Mid-scan reset: assert reset at idx=3 -> an=111111 in the same cycle. After release, the first drive is an=111110 on the 2nd edge.
- With LEADING_ZERO_BLANK_EN, disp_time=24'h000512:
  - digits 5 and 4 show seg=0x7F.
  - digit 3 shows 0x7F.
  - digits 2..0 show 0x12, 0x79, 0x24.
  - Without the macro, digits 5..3 show 0x40.
